// File: rtl/ars_mod_multi_squa.sv
// Sequential k-fold squarer over GF(2^233), f(x) = x^233 + x^74 + 1.
// Applies SQ_PER_CYC squarings per clock to an accumulator until K squarings are done.
module ars_mod_multi_squa #(
    parameter int SQ_PER_CYC = 1,
    parameter int KW         = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [232:0]   din,
    input  logic [KW-1:0]  k,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [232:0]   dout,
    output logic           busy,
    output logic [1:0]     dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid must not depend on ready, and payload is only sampled on that edge.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [232:0]  acc, acc_nxt, sq1, step;
    logic [KW-1:0] cnt, cnt_nxt, dec;

    // ARS_MOD_SQUA: spread coefficients to even positions, then fold bits >= 233
    // down using x^233 = x^74 + 1, highest first so folded bits are re-reduced.
    function automatic logic [232:0] ars_mod_squa(input logic [232:0] a);
        logic [464:0] t;
        t = '0;
        for (int i = 0; i < 233; i++) t[2*i] = a[i];
        for (int i = 464; i >= 233; i--) begin
            if (t[i]) begin
                t[i]       = 1'b0;
                t[i - 233] = ~t[i - 233];
                t[i - 159] = ~t[i - 159];
            end
        end
        return t[232:0];
    endfunction

    assign sq1 = ars_mod_squa(acc);

    generate
        if (SQ_PER_CYC == 1) begin : g_sq1
            assign step = sq1;
            assign dec  = KW'(1);
        end else if (SQ_PER_CYC == 2) begin : g_sq2
            // With one squaring left, stop after the first chained stage.
            assign step = (cnt == KW'(1)) ? sq1 : ars_mod_squa(sq1);
            assign dec  = (cnt == KW'(1)) ? KW'(1) : KW'(2);
        end else begin : g_bad
            $error("SQ_PER_CYC must be 1 or 2");
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            acc   <= acc_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    acc_nxt   = din;
                    cnt_nxt   = k;
                    state_nxt = (k == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                acc_nxt = step;
                cnt_nxt = cnt - dec;
                if (cnt == dec) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == RUN);
    assign out_valid = (state == DONE);
    assign dout      = acc;
    assign dbg_state = state;

endmodule

// File: tb/tb_ars_mod_multi_squa.sv
// Bench for ars_mod_multi_squa: one DUT per SQ_PER_CYC value, driven in lockstep
// and checked against a shift-and-add GF(2^233) multiplier model.
module tb_ars_mod_multi_squa;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic [232:0] din;
    logic [7:0]   k;
    logic         out_ready;
    logic         in_ready1, out_valid1, busy1;
    logic         in_ready2, out_valid2, busy2;
    logic [232:0] dout1, dout2;
    logic [1:0]   dbg_state1, dbg_state2;

    int n_checks = 0;
    int n_fail   = 0;
    logic [232:0] exp_q[$];

    always #5 clk = ~clk;

    ars_mod_multi_squa #(.SQ_PER_CYC(1), .KW(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .din(din), .k(k), .out_valid(out_valid1), .out_ready(out_ready),
        .dout(dout1), .busy(busy1), .dbg_state(dbg_state1)
    );

    ars_mod_multi_squa #(.SQ_PER_CYC(2), .KW(8)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .din(din), .k(k), .out_valid(out_valid2), .out_ready(out_ready),
        .dout(dout2), .busy(busy2), .dbg_state(dbg_state2)
    );

    // Reference field arithmetic: plain polynomial multiply with reduction by f(x).
    function automatic logic [232:0] gf_mul(input logic [232:0] a, input logic [232:0] b);
        logic [232:0] r;
        logic         msb;
        r = '0;
        for (int i = 232; i >= 0; i--) begin
            msb = r[232];
            r   = r << 1;
            if (msb) begin
                r[74] = ~r[74];
                r[0]  = ~r[0];
            end
            if (b[i]) r = r ^ a;
        end
        return r;
    endfunction

    function automatic logic [232:0] gf_pow2k(input logic [232:0] a, input int kk);
        logic [232:0] r;
        r = a;
        for (int i = 0; i < kk; i++) r = gf_mul(r, r);
        return r;
    endfunction

    function automatic logic [232:0] rand_elem();
        logic [255:0] w;
        for (int i = 0; i < 8; i++) w[32*i +: 32] = $urandom;
        return w[232:0];
    endfunction

    // Full transaction on both DUTs: accept, measure latency, optionally stall, release.
    task automatic run_txn(input logic [232:0] a, input int kk, input logic [232:0] expv,
                           input int hold, input string name);
        int lat1, lat2, exp_lat1, exp_lat2;
        logic [232:0] e;
        exp_q.push_back(expv);
        exp_lat1 = kk + 1;
        exp_lat2 = (kk + 1) / 2 + 1;
        @(negedge clk);
        n_checks++;
        if ({in_ready1, in_ready2} !== 2'b11) begin
            n_fail++;
            $display("FAIL %s in_ready before accept: got %b%b want 11", name, in_ready1, in_ready2);
        end
        in_valid = 1'b1;
        din      = a;
        k        = 8'(kk);
        @(negedge clk);
        in_valid = 1'b0;
        din      = rand_elem();
        k        = 8'($urandom);
        lat1 = 0;
        lat2 = 0;
        for (int c = 1; c <= 300 && (lat1 == 0 || lat2 == 0); c++) begin
            if (lat1 == 0 && out_valid1) lat1 = c;
            if (lat2 == 0 && out_valid2) lat2 = c;
            if (c == 1 && kk > 0) begin
                n_checks++;
                if ({busy1, busy2, in_ready1, in_ready2} !== 4'b1100) begin
                    n_fail++;
                    $display("FAIL %s busy/in_ready in run: got %b%b%b%b want 1100", name,
                             busy1, busy2, in_ready1, in_ready2);
                end
            end
            if (lat1 == 0 || lat2 == 0) @(negedge clk);
        end
        e = exp_q.pop_front();
        n_checks++;
        if (lat1 !== exp_lat1) begin
            n_fail++;
            $display("FAIL %s latency sq1: got %0d want %0d (0 = timeout)", name, lat1, exp_lat1);
        end
        n_checks++;
        if (lat2 !== exp_lat2) begin
            n_fail++;
            $display("FAIL %s latency sq2: got %0d want %0d (0 = timeout)", name, lat2, exp_lat2);
        end
        n_checks++;
        if (dout1 !== e) begin
            n_fail++;
            $display("FAIL %s dout sq1: got %h want %h", name, dout1, e);
        end
        n_checks++;
        if (dout2 !== e) begin
            n_fail++;
            $display("FAIL %s dout sq2: got %h want %h", name, dout2, e);
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid1, out_valid2, in_ready1, in_ready2} !== 4'b1100 ||
                dout1 !== e || dout2 !== e) begin
                n_fail++;
                $display("FAIL %s stall cycle %0d: ov=%b%b ir=%b%b d1=%h d2=%h want ov=11 ir=00 d=%h",
                         name, h, out_valid1, out_valid2, in_ready1, in_ready2, dout1, dout2, e);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        n_checks++;
        if ({out_valid1, out_valid2, in_ready1, in_ready2} !== 4'b0011) begin
            n_fail++;
            $display("FAIL %s after release: ov=%b%b ir=%b%b want ov=00 ir=11", name,
                     out_valid1, out_valid2, in_ready1, in_ready2);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if ({in_ready1, out_valid1, busy1, in_ready2, out_valid2, busy2} !== 6'b100100) begin
            n_fail++;
            $display("FAIL reset flags: got %b%b%b %b%b%b want 100 100",
                     in_ready1, out_valid1, busy1, in_ready2, out_valid2, busy2);
        end
        n_checks++;
        if (dout1 !== '0 || dout2 !== '0) begin
            n_fail++;
            $display("FAIL reset dout: got %h %h want 0", dout1, dout2);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({in_ready1, out_valid1, in_ready2, out_valid2} !== 4'b1010) begin
            n_fail++;
            $display("FAIL idle after reset: got %b%b %b%b want 10 10",
                     in_ready1, out_valid1, in_ready2, out_valid2);
        end
    endtask

    task automatic test_directed();
        logic [232:0] one, x2, e;
        one = 233'd1;
        x2  = one << 1;
        run_txn(x2, 3, one << 8, 0, "x2_k3");
        e = (one << 97) | (one << 23);
        run_txn(x2, 8, e, 0, "x2_k8");
        e = (one << 167) | (one << 82) | (one << 8);
        run_txn(one << 200, 1, e, 0, "x200_k1");
        e = rand_elem();
        run_txn(e, 0, e, 0, "k0");
        e = rand_elem();
        run_txn(e, 233, e, 0, "frobenius");
        run_txn(one, 255, one, 0, "k255_one");
    endtask

    task automatic test_hold_back_to_back();
        logic [232:0] a, b;
        a = rand_elem();
        b = rand_elem();
        run_txn(a, 5, gf_pow2k(a, 5), 10, "hold");
        run_txn(b, 2, gf_pow2k(b, 2), 0, "back_to_back");
    endtask

    task automatic test_random();
        logic [232:0] a;
        int kk;
        for (int n = 0; n < 100; n++) begin
            a  = rand_elem();
            kk = $urandom_range(0, 255);
            run_txn(a, kk, gf_pow2k(a, kk), 0, $sformatf("rand%0d", n));
        end
    endtask

    task automatic test_reset_mid_run();
        logic [232:0] a;
        int seen;
        @(negedge clk);
        in_valid = 1'b1;
        din      = rand_elem();
        k        = 8'd200;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready1, out_valid1, busy1, in_ready2, out_valid2, busy2} !== 6'b100100 ||
            dout1 !== '0 || dout2 !== '0) begin
            n_fail++;
            $display("FAIL mid-run reset: flags %b%b%b %b%b%b d1=%h d2=%h want 100 100 and 0",
                     in_ready1, out_valid1, busy1, in_ready2, out_valid2, busy2, dout1, dout2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (250) begin
            @(negedge clk);
            if (out_valid1 || out_valid2) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL no out_valid after reset: got %0d valid cycles want 0", seen);
        end
        a = rand_elem();
        run_txn(a, 17, gf_pow2k(a, 17), 0, "after_reset");
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        din       = '0;
        k         = '0;
        out_ready = 1'b0;
        test_reset();
        test_directed();
        test_hold_back_to_back();
        test_random();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
